// File: rtl/kv_cache_pkg.sv
// ---------------------------------------------------------------------------
// kv_cache_pkg
//   Shared types and helpers for the cache refill path.
//   - fetch_state_e : line fetcher FSM encoding (also exported on a debug port)
//   - line_base()   : clear the line-offset bits of a word address
// ---------------------------------------------------------------------------
package kv_cache_pkg;

  // Widest address line_base() accepts; callers cast to/from their own width.
  localparam int unsigned KV_MAX_ADDR_W = 64;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_FILL = 2'd1,
    FETCH_RESP = 2'd2
  } fetch_state_e;

  // Word address of the first word of the line containing addr.
  function automatic logic [KV_MAX_ADDR_W-1:0] line_base(
    input logic [KV_MAX_ADDR_W-1:0] addr,
    input int unsigned              loff_w
  );
    logic [KV_MAX_ADDR_W-1:0] mask;
    mask = '1;
    mask = mask << loff_w;
    return addr & mask;
  endfunction

endpackage

// File: rtl/kv_wrap_counter.sv
// ---------------------------------------------------------------------------
// kv_wrap_counter
//   Beat counter for one side of a line fill. The count is one bit wider than
//   the line offset so that "all LINE_SIZE beats done" is representable; the
//   offset output is (start + count) wrapped to the line, i.e. the word slot
//   the current beat belongs to in critical-word-first order.
// Ports
//   i_clk     clock
//   i_rst     synchronous active-high reset (count -> 0)
//   i_clr     synchronous clear (count -> 0)
//   i_inc     advance count by one
//   i_start   line offset of the critical word
//   o_count   beats counted so far (LOFF_W+1 bits)
//   o_offset  (i_start + o_count) mod 2**LOFF_W
// ---------------------------------------------------------------------------
module kv_wrap_counter #(
  parameter int unsigned LOFF_W = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_inc,
  input  logic [LOFF_W-1:0] i_start,
  output logic [LOFF_W:0]   o_count,
  output logic [LOFF_W-1:0] o_offset
);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      o_count <= '0;
    end else if (i_inc) begin
      o_count <= o_count + (LOFF_W+1)'(1);
    end
  end

  // Truncating add: the offset wraps inside the line.
  assign o_offset = i_start + o_count[LOFF_W-1:0];

endmodule

// File: rtl/kv_line_fetcher.sv
// ---------------------------------------------------------------------------
// kv_line_fetcher
//   Cache line refill engine. Takes one miss word address, issues LINE_SIZE
//   single-word reads to memory starting at the missed (critical) word and
//   wrapping around the line, collects the in-order read beats into their
//   line slots, and returns the whole line as one response beat.
//   One line in flight at a time.
//
// Handshake semantics (all channels): a transfer happens on the rising edge
//   where valid && ready are both high. The fetcher never drops a valid it has
//   raised before the matching ready, and its payload is held stable while
//   valid waits. o_fetch_ready is the only ready that combinationally depends
//   on an input: in RESP it follows i_fetch_ready so a new miss can be taken
//   in the same cycle the previous line is handed over.
//
// Ports
//   i_clk, i_rst                    clock, synchronous active-high reset
//   i_fetch_addr/valid, o_fetch_ready   miss request from cache
//   o_fetch_data[LINE_SIZE], o_fetch_valid, i_fetch_ready   line response
//   o_mem_addr, o_mem_req_valid, i_mem_req_ready            read requests
//   i_mem_rdata, i_mem_rvalid, o_mem_rready                 read beats
//   o_dbg_state                     current FSM state
// ---------------------------------------------------------------------------
module kv_line_fetcher
  import kv_cache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_SIZE  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_WIDTH-1:0] i_fetch_addr,
  input  logic                  i_fetch_valid,
  output logic                  o_fetch_ready,
  output logic [DATA_WIDTH-1:0] o_fetch_data [LINE_SIZE-1:0],
  output logic                  o_fetch_valid,
  input  logic                  i_fetch_ready,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_req_valid,
  input  logic                  i_mem_req_ready,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  input  logic                  i_mem_rvalid,
  output logic                  o_mem_rready,
  output fetch_state_e          o_dbg_state
);

  localparam int unsigned LOFF_W = $clog2(LINE_SIZE);
  localparam int unsigned CNT_W  = LOFF_W + 1;
  localparam logic [CNT_W-1:0] LINE_CNT = CNT_W'(LINE_SIZE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_SIZE - 1);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] base_d;
  logic [LOFF_W-1:0]     start_q;
  logic [DATA_WIDTH-1:0] line_q [LINE_SIZE-1:0];

  logic [CNT_W-1:0]      iss_cnt, rcv_cnt;
  logic [LOFF_W-1:0]     iss_off, rcv_off;

  logic fetch_hs, resp_hs, req_hs, beat_hs, last_beat;

  // ---------------------------------------------------------------------
  // Output decode (registers only, apart from the RESP fetch_ready bypass)
  // ---------------------------------------------------------------------
  always_comb begin
    o_fetch_ready = 1'b0;
    case (state_q)
      FETCH_IDLE: o_fetch_ready = 1'b1;
      FETCH_RESP: o_fetch_ready = i_fetch_ready;
      default:    o_fetch_ready = 1'b0;
    endcase
  end

  assign o_fetch_valid   = (state_q == FETCH_RESP);
  assign o_mem_req_valid = (state_q == FETCH_FILL) && (iss_cnt < LINE_CNT);
  // A beat is only accepted for a request already issued, so the receive
  // count can never overtake the issue count.
  assign o_mem_rready    = (state_q == FETCH_FILL) && (rcv_cnt < LINE_CNT) &&
                           (rcv_cnt < iss_cnt);
  // base_q has its offset bits clear, so OR-ing in the wrapped offset can
  // never carry into the line address.
  assign o_mem_addr      = base_q | ADDR_WIDTH'(iss_off);
  assign o_fetch_data    = line_q;
  assign o_dbg_state     = state_q;

  assign fetch_hs  = i_fetch_valid && o_fetch_ready;
  assign resp_hs   = o_fetch_valid && i_fetch_ready;
  assign req_hs    = o_mem_req_valid && i_mem_req_ready;
  assign beat_hs   = o_mem_rready && i_mem_rvalid;
  assign last_beat = beat_hs && (rcv_cnt == LAST_CNT);

  assign base_d = ADDR_WIDTH'(line_base(KV_MAX_ADDR_W'(i_fetch_addr), LOFF_W));

  // ---------------------------------------------------------------------
  // Issue / receive counters; both restart when the line is handed over
  // ---------------------------------------------------------------------
  kv_wrap_counter #(.LOFF_W(LOFF_W)) u_iss_cnt (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (resp_hs),
    .i_inc    (req_hs),
    .i_start  (start_q),
    .o_count  (iss_cnt),
    .o_offset (iss_off)
  );

  kv_wrap_counter #(.LOFF_W(LOFF_W)) u_rcv_cnt (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (resp_hs),
    .i_inc    (beat_hs),
    .i_start  (start_q),
    .o_count  (rcv_cnt),
    .o_offset (rcv_off)
  );

  // ---------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_IDLE: if (i_fetch_valid) state_d = FETCH_FILL;
      FETCH_FILL: if (last_beat)     state_d = FETCH_RESP;
      FETCH_RESP: begin
        // A miss arriving with the line hand-over starts its fill at once.
        if (i_fetch_ready) state_d = i_fetch_valid ? FETCH_FILL : FETCH_IDLE;
      end
      default:    state_d = FETCH_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // State, request latch and line buffer
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= FETCH_IDLE;
      base_q  <= '0;
      start_q <= '0;
      for (int i = 0; i < int'(LINE_SIZE); i++) begin
        line_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (fetch_hs) begin
        base_q  <= base_d;
        start_q <= i_fetch_addr[LOFF_W-1:0];
      end
      // Beat k lands in slot (start + k) mod LINE_SIZE.
      if (beat_hs) begin
        line_q[rcv_off] <= i_mem_rdata;
      end
    end
  end

endmodule
